pixel_stream_sequencer: RTL and testbench

Upstream feeder for the kernelRam array of the skeletonization core. Reads an N×N frame from a synchronous frame RAM and broadcasts it in raster order as an address/data stream shared by all kernel units. Each thinning pass is a write sweep (`we`=1, pixels delivered) followed by a read-out sweep (`we`=0, addresses only), and the sequence repeats for a programmed number of passes. Every beat is held for two clocks, so kernel units that sample on alternate clocks see each address exactly once, whatever their phase.

---
 rtl/pixel_stream_sequencer.sv | 146 ++++++++++++++
 tb/tb_pixel_stream_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_sequencer.sv
// Raster-order address/data broadcaster for the kernelRam array: per pass, a write sweep then a
// read-out sweep, each beat held two clocks. Optional early exit under PIXEL_SEQ_CONVERGE_EN.
module pixel_stream_sequencer #(
    parameter int N          = 8,
    parameter int bitSize    = 6,
    parameter int pixelWidth = 8,
    parameter int MAX_PASSES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef PIXEL_SEQ_CONVERGE_EN
    input  logic                  frame_changed,
`endif
    output logic [bitSize:0]      frame_rd_addr,
    input  logic [pixelWidth-1:0] frame_rd_data,
    output logic [bitSize:0]      pixel_position_or_address,
    output logic [pixelWidth-1:0] data_in,
    output logic                  we,
    output logic [3:0]            pass_count,
    output logic                  busy,
    output logic                  done
);
    localparam int             AW   = bitSize + 1;
    localparam logic [AW-1:0]  LAST = AW'(N * N - 1);

    typedef enum logic [2:0] {IDLE, PREFETCH, WRITE, READ, DONE} state_t;

    state_t                 state, state_n;
    logic                   phase, phase_n;
    logic [AW-1:0]          rd_n, addr_n;
    logic [pixelWidth-1:0]  din_n;
    logic                   we_n, busy_n, done_n;
    logic [3:0]             pc_n, pc_inc;
    logic                   stop_early;

`ifdef PIXEL_SEQ_CONVERGE_EN
    assign stop_early = ~frame_changed;
`else
    assign stop_early = 1'b0;
`endif

    assign pc_inc = pass_count + 4'd1;

    // RAM address runs one beat ahead of the broadcast, saturating at the last pixel
    function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] a);
        return (a == LAST) ? a : a + AW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                     <= IDLE;
            phase                     <= 1'b0;
            frame_rd_addr             <= '0;
            pixel_position_or_address <= '0;
            data_in                   <= '0;
            we                        <= 1'b0;
            pass_count                <= '0;
            busy                      <= 1'b0;
            done                      <= 1'b0;
        end else begin
            state                     <= state_n;
            phase                     <= phase_n;
            frame_rd_addr             <= rd_n;
            pixel_position_or_address <= addr_n;
            data_in                   <= din_n;
            we                        <= we_n;
            pass_count                <= pc_n;
            busy                      <= busy_n;
            done                      <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = ~phase;
        rd_n    = frame_rd_addr;
        addr_n  = pixel_position_or_address;
        din_n   = data_in;
        we_n    = we;
        pc_n    = pass_count;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                phase_n = 1'b0;
                rd_n    = '0;
                addr_n  = '0;
                din_n   = '0;
                we_n    = 1'b0;
                busy_n  = 1'b0;
                if (start) begin
                    state_n = PREFETCH;
                    pc_n    = '0;
                    busy_n  = 1'b1;
                end
            end
            PREFETCH: begin
                // frame_rd_addr was already 0 last clock, so mem[0] is on the data bus now
                state_n = WRITE;
                phase_n = 1'b0;
                addr_n  = '0;
                din_n   = frame_rd_data;
                we_n    = 1'b1;
                rd_n    = sat_inc('0);
            end
            WRITE: begin
                if (phase) begin
                    if (pixel_position_or_address == LAST) begin
                        state_n = READ;
                        addr_n  = '0;
                        din_n   = '0;
                        we_n    = 1'b0;
                        rd_n    = '0;
                    end else begin
                        addr_n = pixel_position_or_address + AW'(1);
                        din_n  = frame_rd_data;
                        rd_n   = sat_inc(pixel_position_or_address + AW'(1));
                    end
                end
            end
            READ: begin
                if (phase) begin
                    if (pixel_position_or_address == LAST) begin
                        pc_n   = pc_inc;
                        addr_n = '0;
                        if (pc_inc == 4'(MAX_PASSES) || stop_early) begin
                            state_n = DONE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            state_n = PREFETCH;
                        end
                    end else begin
                        addr_n = pixel_position_or_address + AW'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                phase_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pixel_stream_sequencer.sv
// Randomized-frame bench for pixel_stream_sequencer; expected outputs come from a per-clock
// arithmetic model of the pass schedule (PREFETCH, 2*N*N write clocks, 2*N*N read clocks).
module tb_pixel_stream_sequencer;
    localparam int N    = 8;
    localparam int BS   = 6;
    localparam int PW   = 8;
    localparam int MAXP = 4;
    localparam int NN   = N * N;
    localparam int PL   = 1 + 4 * NN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
`ifdef PIXEL_SEQ_CONVERGE_EN
    logic          frame_changed = 1'b1;
`endif
    logic [BS:0]   frame_rd_addr;
    logic [PW-1:0] frame_rd_data = '0;
    logic [BS:0]   pixel_position_or_address;
    logic [PW-1:0] data_in;
    logic          we;
    logic [3:0]    pass_count;
    logic          busy;
    logic          done;

    logic [PW-1:0] mem [0:(1<<(BS+1))-1];
    int n_vec = 0;
    int n_err = 0;

    pixel_stream_sequencer #(.N(N), .bitSize(BS), .pixelWidth(PW), .MAX_PASSES(MAXP)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .start                     (start),
`ifdef PIXEL_SEQ_CONVERGE_EN
        .frame_changed             (frame_changed),
`endif
        .frame_rd_addr             (frame_rd_addr),
        .frame_rd_data             (frame_rd_data),
        .pixel_position_or_address (pixel_position_or_address),
        .data_in                   (data_in),
        .we                        (we),
        .pass_count                (pass_count),
        .busy                      (busy),
        .done                      (done)
    );

    always #5 clk = ~clk;

    // synchronous frame RAM, one clock read latency
    always @(posedge clk) frame_rd_data <= mem[frame_rd_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {3'b0, busy, done, we, pass_count, frame_rd_addr, pixel_position_or_address, data_in};
    endfunction

    function automatic logic [31:0] pack(input logic b, input logic d, input logic w, input int pc,
                                         input int rd, input int a, input int dt);
        return {3'b0, b, d, w, 4'(pc), 7'(rd), 7'(a), 8'(dt)};
    endfunction

    // Outputs t clocks after PREFETCH entry of a run that stops after np passes
    function automatic logic [31:0] exp_vec(input int t, input int np);
        int p, r, k;
        if (t == np * PL)     return pack(1'b0, 1'b1, 1'b0, np, 0, 0, 0);
        if (t >  np * PL)     return pack(1'b0, 1'b0, 1'b0, np, 0, 0, 0);
        p = t / PL;
        r = t % PL;
        if (r == 0)           return pack(1'b1, 1'b0, 1'b0, p, 0, 0, 0);
        if (r <= 2 * NN) begin
            k = (r - 1) / 2;
            return pack(1'b1, 1'b0, 1'b1, p, (k + 1 < NN) ? k + 1 : NN - 1, k, int'(mem[k]));
        end
        k = (r - 1 - 2 * NN) / 2;
        return pack(1'b1, 1'b0, 1'b0, p, 0, k, 0);
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < (1 << (BS + 1)); i++) mem[i] = PW'($urandom);
    endtask

    // Runs one sequence from start through the IDLE clock after DONE, checking every clock.
    // cut_pass >= 0 drops frame_changed during that pass (converge build only).
    task automatic run_check(input int np, input bit hold, input int cut_pass);
        int seen_e [NN];
        int seen_o [NN];
        int r, ok_e, ok_o;
        start = 1'b1;
        for (int t = 0; t <= np * PL + 1; t++) begin
            @(posedge clk); #1;
            if (t == 0 && !hold) start = 1'b0;
`ifdef PIXEL_SEQ_CONVERGE_EN
            if (cut_pass >= 0 && t == cut_pass * PL) frame_changed = 1'b0;
`endif
            chk("cycle", dut_vec(), exp_vec(t, np));
            // two kernel samplers on opposite clock parities
            if (t < np * PL) begin
                r = t % PL;
                if (r == 1 || r == 2 * NN + 1)
                    for (int i = 0; i < NN; i++) begin seen_e[i] = 0; seen_o[i] = 0; end
                if (r != 0 && int'(pixel_position_or_address) < NN) begin
                    if (t % 2 == 0) seen_e[pixel_position_or_address]++;
                    else            seen_o[pixel_position_or_address]++;
                end
                if (r == 2 * NN || r == 4 * NN) begin
                    ok_e = 0; ok_o = 0;
                    for (int i = 0; i < NN; i++) begin
                        if (seen_e[i] == 1) ok_e++;
                        if (seen_o[i] == 1) ok_o++;
                    end
                    chk("sampler_even", 32'(ok_e), 32'(NN));
                    chk("sampler_odd",  32'(ok_o), 32'(NN));
                end
            end
        end
`ifdef PIXEL_SEQ_CONVERGE_EN
        frame_changed = 1'b1;
`endif
    endtask

    initial begin
        int guard;
        fill_mem();
        repeat (3) @(posedge clk);
        #1 chk("reset_state", dut_vec(), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_check(MAXP, 1'b0, -1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_hold", dut_vec(), pack(1'b0, 1'b0, 1'b0, MAXP, 0, 0, 0));
        end

        // asynchronous reset mid-write at address 37
        fill_mem();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (!(we && pixel_position_or_address == 7'd37) && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reach_addr37", 32'(guard < 500), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", dut_vec(), 32'h0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", dut_vec(), 32'h0);

        fill_mem();
        run_check(MAXP, 1'b0, -1);

        // start held high: no retrigger until IDLE has been seen
        fill_mem();
        run_check(MAXP, 1'b1, -1);
        @(posedge clk); #1;
        chk("retrigger", dut_vec(), exp_vec(0, MAXP));
        start = 1'b0;
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef PIXEL_SEQ_CONVERGE_EN
        fill_mem();
        run_check(2, 1'b0, 1);
        chk("converge_count", 32'(pass_count), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
